// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - valid/ready push channel into the UART transmit FIFO
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with built-in transmit FIFO
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  uart_tx_fifo_if.slave  push,
  input  logic           ovf_clr,
  output logic           tx,
  output logic           busy,
  output logic [CW-1:0]  fifo_count,
  output logic           ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [BW-1:0]     baud, baud_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              par, par_n;
  logic              push_fire, pop, can_pop, bit_end;

  // Ready comes from the registered count only, so a full FIFO refuses even during a pop.
  assign push.din_ready = (count != FULL);
  assign push_fire      = push.din_valid && push.din_ready;
  assign can_pop        = (count != '0) && ena;
  assign bit_end        = (baud == BAUD_LAST);
  assign fifo_count     = count;
  assign busy           = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop)      count <= count + 1'b1;
      else if (!push_fire && pop) count <= count - 1'b1;
      if (push.din_valid && !push.din_ready) ovf <= 1'b1;
      else if (ovf_clr)                      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      par     <= par_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    sh_n    = sh;
    par_n   = par;
    pop     = 1'b0;
    if (state != S_IDLE) baud_n = bit_end ? '0 : baud + 1'b1;
    case (state)
      S_IDLE: if (can_pop) begin
        pop     = 1'b1;
        state_n = S_START;
      end
      S_START: if (bit_end) begin
        state_n = S_DATA;
        bit_n   = '0;
      end
      S_DATA: if (bit_end) begin
        sh_n = sh >> 1;
        if (bit_cnt == DATA_LAST) begin
          state_n = (PARITY != 0) ? S_PAR : S_STOP;
          bit_n   = '0;
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      end
      S_PAR: if (bit_end) begin
        state_n = S_STOP;
        bit_n   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_cnt != STOP_LAST) begin
          bit_n = bit_cnt + 1'b1;
        end else if (can_pop) begin
          // Chain straight into the next start bit so queued frames have no idle gap.
          pop     = 1'b1;
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (pop) begin
      sh_n   = mem[rd_ptr];
      par_n  = (^mem[rd_ptr]) ^ PAR_ODD;
      baud_n = '0;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = sh[0];
      S_PAR:   tx = par;
      default: tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (8N1, 7E2, 7O2 instances)
module tb_uart_tx_fifo;
  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int FL0   = 10 * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n, ena0, clr0, ena_s, clr_s;
  logic tx0, tx1, tx2, bsy0, bsy1, bsy2, ov0, ov1, ov2;
  logic [2:0] cnt0, cnt1, cnt2;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_q[3][$];
  int st0[$];
  int m_cnt = 0;
  int m_rem = 0;
  logic m_ovf = 1'b0;
  bit sec_done = 1'b0;

  uart_tx_fifo_if #(.DATA_W(8)) bus0 ();
  uart_tx_fifo_if #(.DATA_W(7)) bus1 ();
  uart_tx_fifo_if #(.DATA_W(7)) bus2 ();

  uart_tx_fifo #(.CLKS_PER_BIT(C)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .push(bus0), .ovf_clr(clr0),
    .tx(tx0), .busy(bsy0), .fifo_count(cnt0), .ovf(ov0));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_W(7), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst2_n), .ena(ena_s), .push(bus1), .ovf_clr(clr_s),
    .tx(tx1), .busy(bsy1), .fifo_count(cnt1), .ovf(ov1));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_W(7), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .ena(ena_s), .push(bus2), .ovf_clr(clr_s),
    .tx(tx2), .busy(bsy2), .fifo_count(cnt2), .ovf(ov2));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic line(input int idx);
    return (idx == 0) ? tx0 : (idx == 1) ? tx1 : tx2;
  endfunction

  function automatic logic rst_of(input int idx);
    return (idx == 0) ? rst_n : rst2_n;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Line monitor: decodes each frame by mid-bit sampling and scores it against the queue.
  task automatic mon(input int idx, input int dw, input int par, input int sb);
    int nb, d, w, ones;
    logic prev;
    logic [15:0] got;
    bit ab;
    nb = 1 + dw + ((par != 0) ? 1 : 0) + sb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_of(idx)) begin
        prev = 1'b1;
      end else if (prev && !line(idx)) begin
        if (idx == 0) st0.push_back(cyc);
        ab = 1'b0;
        got = '0;
        for (int c = 0; c < nb * C; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_of(idx)) begin
            ab = 1'b1;
            break;
          end
          if (c % C == 2) got[c / C] = line(idx);
        end
        if (!ab) begin
          d = 0;
          for (int i = 0; i < dw; i++) d |= int'(got[1 + i]) << i;
          if (exp_q[idx].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d actual=0x%0h required=none", idx, d);
          end else begin
            w = exp_q[idx].pop_front();
            chk($sformatf("start_bit%0d", idx), int'(got[0]), 0);
            chk($sformatf("data%0d", idx), d, w);
            if (par != 0)
              chk($sformatf("parity%0d", idx), int'(got[1 + dw]),
                  ($countones(w) & 1) ^ ((par == 2) ? 1 : 0));
            ones = 0;
            for (int i = 0; i < sb; i++) ones += int'(got[nb - 1 - i]);
            chk($sformatf("stop_bits%0d", idx), ones, sb);
          end
        end
        prev = line(idx);
      end else begin
        prev = line(idx);
      end
    end
  endtask

  // One clock of dut0 stimulus with a frame-level occupancy/timing reference.
  task automatic step();
    bit push_ok, pop_ok;
    logic nov;
    push_ok = bus0.din_valid && (m_cnt < DEPTH);
    pop_ok  = (m_cnt > 0) && ena0 && (m_rem <= 1);
    nov     = (bus0.din_valid && m_cnt == DEPTH) ? 1'b1 : (clr0 ? 1'b0 : m_ovf);
    if (push_ok) exp_q[0].push_back(int'(bus0.din));
    @(posedge clk);
    #1;
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    m_rem = pop_ok ? FL0 : ((m_rem > 0) ? m_rem - 1 : 0);
    m_ovf = nov;
    chk("fifo_count", int'(cnt0), m_cnt);
    chk("busy", int'(bsy0), (m_rem > 0) ? 1 : 0);
    chk("ovf", int'(ov0), int'(m_ovf));
    chk("din_ready", int'(bus0.din_ready), (m_cnt < DEPTH) ? 1 : 0);
    if (pop_ok) chk("tx_start_at_pop", int'(tx0), 0);
  endtask

  task automatic push0(input logic [7:0] w);
    bus0.din_valid = 1'b1;
    bus0.din = w;
    step();
    bus0.din_valid = 1'b0;
  endtask

  task automatic idle0(input int n);
    repeat (n) step();
  endtask

  initial begin
    fork
      mon(0, 8, 0, 1);
      mon(1, 7, 1, 2);
      mon(2, 7, 2, 2);
    join_none
  end

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    bus1.din_valid = 1'b0;
    bus2.din_valid = 1'b0;
    bus1.din = '0;
    bus2.din = '0;
    wait (rst2_n === 1'b1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w = (i == 0) ? 'h55 : int'($urandom_range(0, 127));
      bus1.din = 7'(w);
      bus2.din = 7'(w);
      bus1.din_valid = 1'b1;
      bus2.din_valid = 1'b1;
      exp_q[1].push_back(w);
      exp_q[2].push_back(w);
      @(posedge clk);
      #1;
      bus1.din_valid = 1'b0;
      bus2.din_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("latency_7e2", int'(tx1), 0);
      chk("latency_7o2", int'(tx2), 0);
      n = 1;
      while (bsy1 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("frame_len_7e2", n - 1, 11 * C);
      chk("busy_end_7o2", int'(bsy2), 0);
      repeat (5) @(negedge clk);
    end
    sec_done = 1'b1;
  end

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    ena0 = 1'b1;
    clr0 = 1'b0;
    ena_s = 1'b1;
    clr_s = 1'b0;
    bus0.din_valid = 1'b0;
    bus0.din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(bsy0), 0);
    chk("rst_count", int'(cnt0), 0);
    chk("rst_ovf", int'(ov0), 0);
    chk("rst_din_ready", int'(bus0.din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    push0(8'hA5);
    idle0(50);

    st0.delete();
    for (int i = 1; i <= 5; i++) push0(8'(i));
    idle0(5 * FL0 + 10);
    chk("b2b_frames", st0.size(), 5);
    for (int i = 1; i < 5 && i < st0.size(); i++) chk("b2b_gap", st0[i] - st0[i - 1], FL0);

    ena0 = 1'b0;
    for (int i = 0; i < DEPTH; i++) push0(8'($urandom));
    push0(8'hEE);
    chk("full_ovf", int'(ov0), 1);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    st0.delete();
    ena0 = 1'b1;
    idle0(4 * FL0 + 10);
    chk("drain_frames", st0.size(), 4);

    push0(8'h00);
    push0(8'h3C);
    push0(8'hC3);
    idle0(14);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx0), 1);
    chk("async_rst_busy", int'(bsy0), 0);
    chk("async_rst_count", int'(cnt0), 0);
    m_cnt = 0;
    m_rem = 0;
    m_ovf = 1'b0;
    exp_q[0].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle0(100);

    push0(8'h81);
    push0(8'h42);
    push0(8'h24);
    idle0(10);
    ena0 = 1'b0;
    idle0(80);
    ena0 = 1'b1;
    idle0(2 * FL0 + 10);

    repeat (400) begin
      bus0.din_valid = ($urandom % 3) == 0;
      bus0.din = 8'($urandom);
      ena0 = ($urandom % 10) != 0;
      clr0 = ($urandom % 20) == 0;
      step();
    end
    bus0.din_valid = 1'b0;
    ena0 = 1'b1;
    clr0 = 1'b0;
    idle0(DEPTH * FL0 + FL0 + 10);

    n_wait : for (int i = 0; i < 2000 && !sec_done; i++) @(posedge clk);
    chk("sec_done", int'(sec_done), 1);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
